// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: shared types and helpers for the frame sequencer.
//   state_t     - sequencer state encoding (S_IDLE, S_RUN)
//   bpb_of()    - bytes per beat for a given stream data width
//   KEEP_ONES   - all-ones tkeep constant, sliced to BPB bits by users
//                 (covers stream widths up to KEEP_MAX_BYTES*8 bits)
package frame_sched_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic int bpb_of(input int dw);
        return dw / 8;
    endfunction

    localparam int KEEP_MAX_BYTES = 4096;
    localparam logic [KEEP_MAX_BYTES-1:0] KEEP_ONES = '1;

endpackage

// File: rtl/frame_sched_keep.sv
// frame_sched_keep: combinational tkeep/tlast generator.
// Ports:
//   bytes_left - bytes still to send in the current frame (never 0 in RUN)
//   keep       - byte-enable for the current beat
//   last       - 1 when this beat ends the frame
// A beat is the last one when bytes_left fits in a single beat; only then is
// keep trimmed to the low bytes_left lanes, otherwise every lane is valid.
module frame_sched_keep
    import frame_sched_pkg::*;
#(
    parameter  int DW  = 5120,
    localparam int BPB = bpb_of(DW)
) (
    input  logic [31:0]    bytes_left,
    output logic [BPB-1:0] keep,
    output logic           last
);

    always_comb begin
        last = (bytes_left <= 32'(BPB));
        keep = KEEP_ONES[BPB-1:0];
        if (last) begin
            for (int i = 0; i < BPB; i++) begin
                keep[i] = (32'(i) < bytes_left);
            end
        end
    end

endmodule

// File: rtl/frame_sched.sv
// frame_sched: frame sequencer between the frame-data input stream and the
// two AXI-Stream output ports. A start strobe runs frame_count frames of
// frame_size bytes; frames are steered to out0/out1, with tlast/tkeep
// generated per beat from a registered byte down-counter.
//
// Handshake: a beat transfers on a rising clk edge where the selected
// output has tvalid & tready both high. Output tvalid is the upstream tvalid
// gated by state/selection and never looks at any tready; axis_df_tready is
// the selected output's tready. Data is passed through with no register.
//
// Ports:
//   clk, resetn                 - clock, asynchronous active-low reset
//   start, frame_count,
//   frame_size                  - run request (values sampled on start)
//   abort                       - finish the current frame, then stop
//   idle, frames_sent           - status to the register file
//   axis_df_*                   - input frame stream
//   axis_out0_*, axis_out1_*    - output streams
//
// Build option FRAME_SCHED_PINGPONG_EN: when defined, consecutive frames
// alternate between out0 and out1. When undefined, every frame goes to out0,
// out1 tvalid/tlast/tkeep are held at 0 and out1 tready is ignored.
module frame_sched
    import frame_sched_pkg::*;
#(
    parameter  int DW  = 5120,
    localparam int BPB = bpb_of(DW)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [31:0]    frame_count,
    input  logic [31:0]    frame_size,
    input  logic           abort,
    output logic           idle,
    output logic [31:0]    frames_sent,
    input  logic [DW-1:0]  axis_df_tdata,
    input  logic           axis_df_tvalid,
    output logic           axis_df_tready,
    output logic [DW-1:0]  axis_out0_tdata,
    output logic [BPB-1:0] axis_out0_tkeep,
    output logic           axis_out0_tlast,
    output logic           axis_out0_tvalid,
    input  logic           axis_out0_tready,
    output logic [DW-1:0]  axis_out1_tdata,
    output logic [BPB-1:0] axis_out1_tkeep,
    output logic           axis_out1_tlast,
    output logic           axis_out1_tvalid,
    input  logic           axis_out1_tready
);

    state_t      state;
    logic        sel;
    logic        abort_pending;
    logic [31:0] frames_left;
    logic [31:0] bytes_left;
    logic [31:0] size_q;

    logic [BPB-1:0] keep_raw;
    logic           last_raw;
    logic           run;
    logic           sel_ready;
    logic           beat;
    logic           sel_next;

    frame_sched_keep #(.DW(DW)) u_keep (
        .bytes_left (bytes_left),
        .keep       (keep_raw),
        .last       (last_raw)
    );

    assign run = (state == S_RUN);

`ifdef FRAME_SCHED_PINGPONG_EN
    assign sel_ready        = sel ? axis_out1_tready : axis_out0_tready;
    assign sel_next         = ~sel;
    assign axis_out1_tvalid = run & sel & axis_df_tvalid;
    assign axis_out1_tlast  = run & sel & last_raw;
    assign axis_out1_tkeep  = (run & sel) ? keep_raw : '0;
`else
    logic unused_out1_tready;
    assign unused_out1_tready = axis_out1_tready;
    assign sel_ready          = axis_out0_tready;
    assign sel_next           = 1'b0;
    assign axis_out1_tvalid   = 1'b0;
    assign axis_out1_tlast    = 1'b0;
    assign axis_out1_tkeep    = '0;
`endif

    assign axis_out0_tdata  = axis_df_tdata;
    assign axis_out1_tdata  = axis_df_tdata;
    assign axis_out0_tvalid = run & ~sel & axis_df_tvalid;
    assign axis_out0_tlast  = run & ~sel & last_raw;
    assign axis_out0_tkeep  = (run & ~sel) ? keep_raw : '0;

    assign axis_df_tready = run & sel_ready;
    assign beat           = run & axis_df_tvalid & sel_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            idle          <= 1'b1;
            frames_sent   <= '0;
            sel           <= 1'b0;
            abort_pending <= 1'b0;
            frames_left   <= '0;
            bytes_left    <= '0;
            size_q        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (frame_count != '0) && (frame_size != '0)) begin
                        state         <= S_RUN;
                        idle          <= 1'b0;
                        frames_left   <= frame_count;
                        bytes_left    <= frame_size;
                        size_q        <= frame_size;
                        frames_sent   <= '0;
                        sel           <= 1'b0;
                        abort_pending <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        abort_pending <= 1'b1;
                    end
                    if (beat) begin
                        if (last_raw) begin
                            frames_sent <= frames_sent + 32'd1;
                            frames_left <= frames_left - 32'd1;
                            bytes_left  <= size_q;
                            sel         <= sel_next;
                            // An abort seen on the final beat itself also ends here.
                            if ((frames_left == 32'd1) || abort_pending || abort) begin
                                state <= S_IDLE;
                                idle  <= 1'b1;
                            end
                        end else begin
                            bytes_left <= bytes_left - 32'(BPB);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_sched.md
# frame_sched

Frame sequencer that sits between the frame-data input stream and the two AXI-Stream output ports of the datapath. On a start strobe from the AXI4-Lite register logic it passes exactly `frame_count` frames of `frame_size` bytes from the input stream, steering them to the two outputs. It generates `tlast` and `tkeep` for every output beat and reports busy/idle status back to the register file.

## Interface

Parameters:
- `DW`, 5120: stream data width in bits; must be a multiple of 8.
- `BPB`, derived as DW/8: bytes per beat (640 by default). Not overridable.

Ports:
- `clk`  in  1  single clock for all logic.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle strobe that begins a run.
- `frame_count`  in  32  number of frames in the run; sampled on `start`.
- `frame_size`  in  32  frame length in bytes; sampled on `start`.
- `abort`  in  1  one-cycle strobe: finish the current frame, then stop.
- `idle`  out  1  1 = no run in progress. Feeds the REG_START readback.
- `frames_sent`  out  32  frames completed in the current or most recent run.
- `axis_df_tdata/tvalid/tready`  in/in/out  DW/1/1  input frame stream.
- `axis_out0_tdata/tkeep/tlast/tvalid/tready`  out/out/out/out/in  DW/DW/8/1/1/1  output 0.
- `axis_out1_*`  same widths and directions as output 0.

## Operation

States:
- IDLE: `idle`=1. All output `tvalid`=0 and `axis_df_tready`=0.
- RUN: exactly one output is selected (`sel`), and the input stream is passed to it.

Transitions:
- IDLE -> RUN on `start` when `frame_count`≠0 and `frame_size`≠0.
- A `start` with either value 0 is ignored: the block stays IDLE and `frames_sent` is unchanged.
- On an accepted `start`:
  - latch `frame_count` into `frames_left`;
  - load `bytes_left` with `frame_size`;
  - clear `frames_sent` to 0;
  - set `sel` to 0;
  - clear `abort_pending`.
- `start` in RUN is ignored.

Pass-through in RUN:
- `tdata` of both outputs = `axis_df_tdata`.
- Selected output: `tvalid` = `axis_df_tvalid`. Unselected output: `tvalid`=0.
- `axis_df_tready` = `tready` of the selected output.

Beats:
- A beat is a transfer: selected `tvalid` & `tready`.
- Non-last beat: `bytes_left` > BPB. `tkeep` is all ones, `tlast`=0, and `bytes_left` decrements by BPB on transfer.
- Last beat: `bytes_left` ≤ BPB. `tlast`=1 and `tkeep` has its low `bytes_left` bits set.

End of frame (last beat transferred):
- `frames_sent`++ and `frames_left`--.
- `bytes_left` reloads from the latched frame size.
- `sel` toggles.
- If `frames_left` was 1 or `abort_pending`=1, the block goes to IDLE.

Abort:
- `abort` in RUN sets `abort_pending`.
- `abort` arriving in the same cycle as a last-beat transfer ends the run at that frame.
- `abort` in IDLE has no effect.

Width rules: `bytes_left` is 32 bits. There is no division; the beat count is implicit in the down-counter.

## Timing

Reset (asynchronous, immediate, mid-frame included):
- state = IDLE, `idle`=1, `frames_sent`=0, `sel`=0.
- All `tvalid`=0, `tlast`=0, `tkeep`=0.
- `axis_df_tready`=0.
- A partial frame is dropped with no `tlast`.

Latency:
- `start` at cycle N: `idle`=0 at N+1, and the first beat may transfer at N+1.
- Zero-latency combinational pass-through: no data register. `tlast` and `tkeep` come from registered `bytes_left`.

Frame boundaries:
- The next frame may transfer in the cycle immediately after the previous frame's last beat, on the other output.
- `idle` rises the cycle after the final last-beat transfer.

Handshake rules:
- Output `tvalid` never depends on output `tready`.
- While an output is stalled, `tdata`, `tkeep` and `tlast` stay stable because upstream holds its data.

## Configuration

`FRAME_SCHED_PINGPONG_EN`:
- Defined: frames alternate between out0 and out1, as described above.
- Undefined:
  - `sel` is fixed at 0 and every frame goes to out0;
  - out1 `tvalid`, `tlast` and `tkeep` are tied to 0;
  - out1 `tready` is ignored.

## Structure

Package `frame_sched_pkg`:
- state enum `{S_IDLE, S_RUN}`;
- `BPB` as a function of DW;
- the `tkeep` all-ones constant.

Sub-module `frame_sched_keep`: combinational; computes `tkeep` and `tlast` from `bytes_left` and DW.

## Test plan

- `frame_count`=4, `frame_size`=1500, always ready -> 3 beats per frame. `tkeep` = all ones, all ones, then low 220 bits. Frames go to out0, out1, out0, out1. `frames_sent`=4 and `idle`=1 the cycle after the 12th beat.
- `frame_size`=640 -> every beat has `tlast`=1 with all-ones `tkeep`. `frame_size`=641 -> 2 beats, last `tkeep`=1 bit.
- `abort` during beat 2 of frame 1 of a 5-frame run -> frame 1 completes on out1, then IDLE with `frames_sent`=2. `abort` in IDLE -> no change.
- Random `tvalid`/`tready` stalls on 3×2000-byte frames -> no lost or duplicated beats, `tdata` stable under stall, `axis_df_tready` mirrors the selected `tready`.
- `start` with `frame_count`=0, and `start` with `frame_size`=0 -> `idle` stays 1. A second `start` mid-run is ignored.
- `resetn` low mid-frame -> `tvalid`=0 and `idle`=1 immediately. The next `start` begins on out0 with a full `bytes_left`.
